// File: rtl/game_data_frame_latch_pkg.sv
// Shared game-state types for the VGA draw path: field geometry, piece descriptor,
// and the game_data_t snapshot that is handed from game logic to the display side.
package game_data_frame_latch_pkg;

  localparam int FIELD_ROW_CNT       = 20;
  localparam int FIELD_COL_CNT       = 10;
  localparam int TETRIS_COLORS_WIDTH = 3;
  localparam int BCD_DIGITS          = 6;

  typedef enum logic [2:0] {
    BLOCK_I    = 3'd0,
    BLOCK_J    = 3'd1,
    BLOCK_L    = 3'd2,
    BLOCK_O    = 3'd3,
    BLOCK_S    = 3'd4,
    BLOCK_T    = 3'd5,
    BLOCK_Z    = 3'd6,
    BLOCK_NONE = 3'd7
  } block_type_t;

  typedef struct packed {
    block_type_t                    block_type;
    logic [1:0]                     rotation;
    logic [3:0]                     x;
    logic [4:0]                     y;
    logic [TETRIS_COLORS_WIDTH-1:0] color;
  } block_info_t;

  typedef logic [FIELD_ROW_CNT-1:0][FIELD_COL_CNT-1:0][TETRIS_COLORS_WIDTH-1:0] field_t;
  typedef logic [BCD_DIGITS-1:0][3:0] bcd_t;

  // One complete frame's worth of game state; pending and display copies are each one of these.
  typedef struct packed {
    field_t      field;
    bcd_t        score;
    bcd_t        lines;
    bcd_t        level;
    block_info_t next_block;
    logic        next_block_draw_en;
    logic        game_over_state;
  } game_data_t;

  function automatic logic vs_is_active(input logic vs, input logic polarity);
    return vs == polarity;
  endfunction

endpackage

// File: rtl/game_data_frame_latch_vs_frame_edge.sv
// Vertical-sync edge detector and frame counter for the pixel-clock domain.
// Edge = vs becomes active after having been inactive at the previous sample.
module vs_frame_edge
  import game_data_frame_latch_pkg::*;
#(
  parameter logic VS_POLARITY     = 1'b0,
  parameter int   FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       vga_vs_i,
  output logic                       frame_edge_o,
  output logic                       frame_start_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

  logic vs_d1;

  // Reset parks vs_d1 at the active level so a vs already active at release is not an edge.
  assign frame_edge_o = vs_is_active(vga_vs_i, VS_POLARITY) && !vs_is_active(vs_d1, VS_POLARITY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_d1         <= VS_POLARITY;
      frame_start_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      vs_d1         <= vga_vs_i;
      frame_start_o <= frame_edge_o;
      if (frame_edge_o) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_data_frame_latch.sv
// Tear-free latch between game logic and the VGA drawing path: one pending snapshot,
// committed to the display copy at vsync. Optional: TETRIS_GAME_OVER_BLINK_EN.
module game_data_frame_latch
  import game_data_frame_latch_pkg::*;
#(
  parameter logic VS_POLARITY     = 1'b0,
  parameter int   FRAME_CNT_WIDTH = 8,
  parameter int   BLINK_BIT       = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       vga_vs_i,

  input  logic                       upd_valid_i,
  output logic                       upd_ready_o,
  input  logic [FIELD_ROW_CNT-1:0][FIELD_COL_CNT-1:0][TETRIS_COLORS_WIDTH-1:0] upd_field_i,
  input  logic [BCD_DIGITS-1:0][3:0] upd_score_i,
  input  logic [BCD_DIGITS-1:0][3:0] upd_lines_i,
  input  logic [BCD_DIGITS-1:0][3:0] upd_level_i,
  input  block_info_t                upd_next_block_i,
  input  logic                       upd_next_block_draw_en_i,
  input  logic                       upd_game_over_state_i,

  output logic [FIELD_ROW_CNT-1:0][FIELD_COL_CNT-1:0][TETRIS_COLORS_WIDTH-1:0] disp_field_o,
  output logic [BCD_DIGITS-1:0][3:0] disp_score_o,
  output logic [BCD_DIGITS-1:0][3:0] disp_lines_o,
  output logic [BCD_DIGITS-1:0][3:0] disp_level_o,
  output block_info_t                disp_next_block_o,
  output logic                       disp_next_block_draw_en_o,
  output logic                       disp_game_over_state_o,

  output logic                       frame_start_o,
  output logic                       commit_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

  logic       frame_edge;
  logic       pending_full_q;
  logic       accept;
  logic       commit;
  game_data_t upd_data;
  game_data_t pending_q;
  game_data_t disp_q;

  vs_frame_edge #(
    .VS_POLARITY    (VS_POLARITY),
    .FRAME_CNT_WIDTH(FRAME_CNT_WIDTH)
  ) u_vs_frame_edge (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vga_vs_i     (vga_vs_i),
    .frame_edge_o (frame_edge),
    .frame_start_o(frame_start_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  assign upd_data = '{
    field:              upd_field_i,
    score:              upd_score_i,
    lines:              upd_lines_i,
    level:              upd_level_i,
    next_block:         upd_next_block_i,
    next_block_draw_en: upd_next_block_draw_en_i,
    game_over_state:    upd_game_over_state_i
  };

  // Accept needs an empty buffer and commit needs a full one, so they are mutually exclusive.
  assign upd_ready_o = !pending_full_q;
  assign accept      = upd_valid_i && !pending_full_q;
  assign commit      = frame_edge && pending_full_q;

  // Pending data is qualified by pending_full_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pending_q <= upd_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_full_q <= 1'b0;
      commit_o       <= 1'b0;
      disp_q         <= '0;
    end else begin
      commit_o <= commit;
      if (commit) begin
        disp_q         <= pending_q;
        pending_full_q <= 1'b0;
      end else if (accept) begin
        pending_full_q <= 1'b1;
      end
    end
  end

  assign disp_field_o              = disp_q.field;
  assign disp_score_o              = disp_q.score;
  assign disp_lines_o              = disp_q.lines;
  assign disp_level_o              = disp_q.level;
  assign disp_next_block_o         = disp_q.next_block;
  assign disp_next_block_draw_en_o = disp_q.next_block_draw_en;

  if (BLINK_BIT < 0) begin : g_blink_bit_negative
    $error("BLINK_BIT (%0d) must not be negative", BLINK_BIT);
  end

`ifdef TETRIS_GAME_OVER_BLINK_EN
  if (BLINK_BIT >= FRAME_CNT_WIDTH) begin : g_blink_bit_range
    $error("BLINK_BIT (%0d) must be below FRAME_CNT_WIDTH (%0d)", BLINK_BIT, FRAME_CNT_WIDTH);
  end

  logic game_over_blink_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      game_over_blink_q <= 1'b0;
    end else begin
      game_over_blink_q <= disp_q.game_over_state && frame_cnt_o[BLINK_BIT];
    end
  end

  assign disp_game_over_state_o = game_over_blink_q;
`else
  assign disp_game_over_state_o = disp_q.game_over_state;
`endif

endmodule

// File: tb/tb_game_data_frame_latch.sv
// Directed bench for game_data_frame_latch: per-cycle scoreboard against a snapshot-queue
// model plus hand-computed expectations at the interesting moments.
module tb_game_data_frame_latch;
  import game_data_frame_latch_pkg::*;

  localparam logic VS_POL    = 1'b0;
  localparam int   CW        = 8;
  localparam int   BLINK_BIT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs;
  logic        valid;
  game_data_t  upd;
  logic        ready;
  field_t      disp_field;
  bcd_t        disp_score, disp_lines, disp_level;
  block_info_t disp_next_block;
  logic        disp_draw_en, disp_go;
  logic        frame_start, commit;
  logic [CW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int nframes = 0;

  game_data_frame_latch #(
    .VS_POLARITY(VS_POL),
    .FRAME_CNT_WIDTH(CW),
    .BLINK_BIT(BLINK_BIT)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .vga_vs_i                 (vs),
    .upd_valid_i              (valid),
    .upd_ready_o              (ready),
    .upd_field_i              (upd.field),
    .upd_score_i              (upd.score),
    .upd_lines_i              (upd.lines),
    .upd_level_i              (upd.level),
    .upd_next_block_i         (upd.next_block),
    .upd_next_block_draw_en_i (upd.next_block_draw_en),
    .upd_game_over_state_i    (upd.game_over_state),
    .disp_field_o             (disp_field),
    .disp_score_o             (disp_score),
    .disp_lines_o             (disp_lines),
    .disp_level_o             (disp_level),
    .disp_next_block_o        (disp_next_block),
    .disp_next_block_draw_en_o(disp_draw_en),
    .disp_game_over_state_o   (disp_go),
    .frame_start_o            (frame_start),
    .commit_o                 (commit),
    .frame_cnt_o              (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic game_data_t mk(input int tag, input logic [23:0] score);
    game_data_t d;
    d = '0;
    for (int r = 0; r < FIELD_ROW_CNT; r++)
      for (int c = 0; c < FIELD_COL_CNT; c++)
        d.field[r][c] = TETRIS_COLORS_WIDTH'(tag + r * 3 + c);
    d.score              = score;
    d.lines              = 24'(tag * 7);
    d.level              = 24'(tag + 1);
    d.next_block         = block_info_t'($bits(block_info_t)'(tag * 37 + 5));
    d.next_block_draw_en = tag[0];
    d.game_over_state    = 1'b0;
    return d;
  endfunction

  // Model: frames counted from vs transitions, snapshots held in a queue of depth one.
  bit         m_prev_act = 1'b1;
  int         m_cnt      = 0;
  game_data_t m_pend[$];
  game_data_t m_disp     = '0;
  bit         m_start    = 1'b0;
  bit         m_commit   = 1'b0;
  bit         m_blink    = 1'b0;

  initial forever begin
    bit act, fe, empty;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_prev_act = 1'b1;
      m_cnt      = 0;
      m_pend.delete();
      m_disp     = '0;
      m_start    = 1'b0;
      m_commit   = 1'b0;
      m_blink    = 1'b0;
    end else begin
      m_blink    = m_disp.game_over_state && (((m_cnt >> BLINK_BIT) & 1) == 1);
      act        = (vs == VS_POL);
      fe         = act && !m_prev_act;
      m_prev_act = act;
      empty      = (m_pend.size() == 0);
      m_start    = fe;
      m_commit   = 1'b0;
      if (fe) m_cnt = (m_cnt + 1) % (1 << CW);
      if (fe && !empty) begin
        m_disp   = m_pend.pop_front();
        m_commit = 1'b1;
      end else if (valid && empty) begin
        m_pend.push_back(upd);
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      logic exp_go;
      @(negedge clk);
`ifdef TETRIS_GAME_OVER_BLINK_EN
      exp_go = m_blink;
`else
      exp_go = m_disp.game_over_state;
`endif
      chk("ready",       96'(ready),       96'(m_pend.size() == 0));
      chk("frame_start", 96'(frame_start), 96'(m_start));
      chk("commit",      96'(commit),      96'(m_commit));
      chk("frame_cnt",   96'(frame_cnt),   96'(m_cnt));
      chk("disp_score",  96'(disp_score),  96'(m_disp.score));
      chk("disp_lines",  96'(disp_lines),  96'(m_disp.lines));
      chk("disp_level",  96'(disp_level),  96'(m_disp.level));
      chk("disp_next",   96'(disp_next_block), 96'(m_disp.next_block));
      chk("disp_draw_en",96'(disp_draw_en), 96'(m_disp.next_block_draw_en));
      chk("disp_go",     96'(disp_go),     96'(exp_go));
      for (int r = 0; r < FIELD_ROW_CNT; r++)
        chk($sformatf("disp_field_row%0d", r), 96'(disp_field[r]), 96'(m_disp.field[r]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n_inactive);
    vs = ~VS_POL;
    repeat (n_inactive) step();
    vs = VS_POL;
    step();
    nframes++;
  endtask

  initial begin
    vs = VS_POL;
    valid = 1'b0;
    upd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 96'(ready), 96'(1));
    chk("rst_cnt",   96'(frame_cnt), 96'(0));
    chk("rst_score", 96'(disp_score), 96'(0));
    rst = 1'b0;

    // vs held active through release: no frame until inactive -> active
    repeat (5) step();
    chk("held_vs_no_start", 96'(frame_start), 96'(0));
    chk("held_vs_cnt",      96'(frame_cnt), 96'(0));
    frame(3);
    chk("first_start", 96'(frame_start), 96'(1));
    chk("first_cnt",   96'(frame_cnt), 96'(1));
    chk("first_no_commit", 96'(commit), 96'(0));

    // single snapshot mid-frame
    step();
    upd = mk(1, 24'h000123);
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk("acc_ready_low", 96'(ready), 96'(0));
    chk("acc_score_held", 96'(disp_score), 96'(0));
    repeat (4) step();
    chk("pend_score_held", 96'(disp_score), 96'(0));
    frame(3);
    chk("c1_commit", 96'(commit), 96'(1));
    chk("c1_start",  96'(frame_start), 96'(1));
    chk("c1_score",  96'(disp_score), 96'(24'h000123));
    chk("c1_ready",  96'(ready), 96'(1));

    // back-to-back snapshots with valid held
    step();
    upd = mk(2, 24'h000001);
    valid = 1'b1;
    step();
    upd = mk(3, 24'h000002);
    repeat (3) step();
    chk("b2b_ready_low", 96'(ready), 96'(0));
    chk("b2b_old_score", 96'(disp_score), 96'(24'h000123));
    frame(3);
    chk("b2b_c1_commit", 96'(commit), 96'(1));
    chk("b2b_c1_score",  96'(disp_score), 96'(24'h000001));
    chk("b2b_ready_up",  96'(ready), 96'(1));
    step();
    valid = 1'b0;
    chk("b2b_second_taken", 96'(ready), 96'(0));
    repeat (3) step();
    chk("b2b_wait_score", 96'(disp_score), 96'(24'h000001));
    frame(3);
    chk("b2b_c2_commit", 96'(commit), 96'(1));
    chk("b2b_c2_score",  96'(disp_score), 96'(24'h000002));
    chk("b2b_cnt",       96'(frame_cnt), 96'(4));

    // counter wrap with no pending snapshots
    for (int i = 0; i < 260; i++) begin
      frame(1);
      chk("idle_no_commit", 96'(commit), 96'(0));
      if ((nframes % 256) == 0) chk("wrap_zero", 96'(frame_cnt), 96'(0));
    end
    chk("wrap_cnt",   96'(frame_cnt), 96'(nframes % 256));
    chk("wrap_score", 96'(disp_score), 96'(24'h000002));

    // reset with a pending snapshot mid-frame
    step();
    upd = mk(4, 24'h999999);
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk("rp_ready_low", 96'(ready), 96'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("rp_score_clr", 96'(disp_score), 96'(0));
    chk("rp_ready",     96'(ready), 96'(1));
    chk("rp_cnt",       96'(frame_cnt), 96'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nframes = 0;
    frame(2);
    chk("rp_no_commit", 96'(commit), 96'(0));
    frame(2);
    chk("rp_score_stays", 96'(disp_score), 96'(0));
    chk("rp_cnt_after",   96'(frame_cnt), 96'(2));

    // game over
    step();
    upd = mk(5, 24'h000500);
    upd.game_over_state = 1'b1;
    valid = 1'b1;
    step();
    valid = 1'b0;
    frame(2);
    chk("go_commit", 96'(commit), 96'(1));
    chk("go_score",  96'(disp_score), 96'(24'h000500));
`ifndef TETRIS_GAME_OVER_BLINK_EN
    chk("go_set", 96'(disp_go), 96'(1));
`endif
    for (int i = 0; i < 70; i++) frame(1);
`ifndef TETRIS_GAME_OVER_BLINK_EN
    chk("go_steady", 96'(disp_go), 96'(1));
`endif
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
